// File: rtl/ubit_window_acc_if.sv
// Host-side bundle for ubit_window_acc: control, unary input stream and the
// valid/ready result port. master = host/driver side, slave = accumulator.
interface ubit_window_acc_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             abort;
  logic             in_bit;
  logic             in_en;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_data;
  logic             overrun;

  modport master (
    output start, abort, in_bit, in_en, out_ready,
    input  busy, out_valid, out_data, overrun
  );

  modport slave (
    input  start, abort, in_bit, in_en, out_ready,
    output busy, out_valid, out_data, overrun
  );
endinterface

// File: rtl/ubit_window_acc.sv
// Counts ones of a unary bitstream over 2^WIDTH enabled samples, one result per window.
// Optional UBIT_ACC_BIPOLAR_EN: result is offset by -2^(WIDTH-1) (two's complement).
module ubit_window_acc #(
  parameter int WIDTH      = 8,
  parameter int CONTINUOUS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  ubit_window_acc_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic CONT = (CONTINUOUS != 0);

  state_t           state, state_next;
  logic [WIDTH:0]   ones_cnt;
  logic [WIDTH-1:0] sample_cnt;
  logic [WIDTH:0]   final_cnt;
  logic [WIDTH:0]   result;
  logic [WIDTH:0]   out_data_q;
  logic             out_valid_q;
  logic             overrun_q;
  logic             hs, start_ok, win_end, load, clear_cnt;

  // NOTE: every signal written in an always_comb gets a value at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    hs        = out_valid_q && bus.out_ready;
    start_ok  = bus.start && ((state == IDLE) || (CONT && (state == ACC)));
    win_end   = (state == ACC) && bus.in_en && (sample_cnt == '1);
    load      = win_end && !bus.abort && !start_ok;
    clear_cnt = bus.abort || start_ok || win_end;
    // The final sample of a window is folded in on the loading edge.
    final_cnt = ones_cnt + {{WIDTH{1'b0}}, bus.in_bit};
  end

`ifdef UBIT_ACC_BIPOLAR_EN
  localparam logic [WIDTH:0] BIAS = (WIDTH+1)'(1) << (WIDTH-1);
  assign result = final_cnt - BIAS;
`else
  assign result = final_cnt;
`endif

  always_comb begin
    state_next = state;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start_ok) state_next = ACC;
        ACC: begin
          if (start_ok)     state_next = ACC;
          else if (win_end) state_next = CONT ? ACC : DONE;
        end
        DONE:    if (hs) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt   <= '0;
      sample_cnt <= '0;
    end else if (clear_cnt) begin
      ones_cnt   <= '0;
      sample_cnt <= '0;
    end else if ((state == ACC) && bus.in_en) begin
      ones_cnt   <= final_cnt;
      sample_cnt <= sample_cnt + WIDTH'(1);
    end
  end

  // A pending result survives abort; only a handshake or a newer result replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result;
      end else if (hs) begin
        out_valid_q <= 1'b0;
      end

      if (start_ok)
        overrun_q <= 1'b0;
      else if (load && out_valid_q && !bus.out_ready)
        overrun_q <= 1'b1;
    end
  end

  assign bus.busy      = (state == ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_ubit_window_acc.sv
// Scoreboard bench for ubit_window_acc (WIDTH=4): one single-shot and one
// continuous instance; monitors pop expected results on each handshake.
module tb_ubit_window_acc;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: single-shot instance, index 1: continuous instance.
  logic st [2];
  logic ab [2];
  logic bi [2];
  logic en [2];
  logic rdy[2];

  ubit_window_acc_if #(.WIDTH(W)) if0 ();
  ubit_window_acc_if #(.WIDTH(W)) if1 ();

  assign if0.start = st[0];  assign if0.abort = ab[0];  assign if0.in_bit = bi[0];
  assign if0.in_en = en[0];  assign if0.out_ready = rdy[0];
  assign if1.start = st[1];  assign if1.abort = ab[1];  assign if1.in_bit = bi[1];
  assign if1.in_en = en[1];  assign if1.out_ready = rdy[1];

  ubit_window_acc #(.WIDTH(W), .CONTINUOUS(0)) u_single (.clk(clk), .rst_n(rst_n), .bus(if0));
  ubit_window_acc #(.WIDTH(W), .CONTINUOUS(1)) u_cont   (.clk(clk), .rst_n(rst_n), .bus(if1));

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q0[$];
  logic [W:0] exp_q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected result for a window holding `ones` ones.
  function automatic logic [W:0] exp_res(input int ones);
    logic [W:0] v;
    v = (W+1)'(ones);
`ifdef UBIT_ACC_BIPOLAR_EN
    v = v - (W+1)'(8);
`endif
    return v;
  endfunction

  // Drive one DUT's inputs for a cycle (the other idles), consume the edge, return #1 after it.
  task automatic cycle(input int d, input logic s, input logic a, input logic b, input logic e);
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; ab[k] = 1'b0; bi[k] = 1'b0; en[k] = 1'b0;
    end
    st[d] = s; ab[d] = a; bi[d] = b; en[d] = e;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && if0.out_valid && if0.out_ready) begin
      if (exp_q0.size() == 0) check("single_unexpected_result", 32'(if0.out_data), 32'hDEAD);
      else                    check("single_result", 32'(if0.out_data), 32'(exp_q0.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (rst_n && if1.out_valid && if1.out_ready) begin
      if (exp_q1.size() == 0) check("cont_unexpected_result", 32'(if1.out_data), 32'hDEAD);
      else                    check("cont_result", 32'(if1.out_data), 32'(exp_q1.pop_front()));
    end
  end

  initial begin
    int n_en;
    int k;
    logic seen;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; ab[i] = 1'b0; bi[i] = 1'b0; en[i] = 1'b0; rdy[i] = 1'b0;
    end

    // Reset values, then a reset asserted in the middle of a window.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_busy0", 32'(if0.busy), 0);
    check("rst_valid0", 32'(if0.out_valid), 0);
    check("rst_valid1", 32'(if1.out_valid), 0);
    check("rst_data1", 32'(if1.out_data), 0);
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 1);
    check("mid_busy", 32'(if0.busy), 1);
    rst_n = 1'b0;
    #1;
    check("async_busy", 32'(if0.busy), 0);
    check("async_valid", 32'(if0.out_valid), 0);
    check("async_data", 32'(if0.out_data), 0);
    check("async_overrun", 32'(if0.overrun), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 1, 1);
      if (if0.out_valid || if0.busy) seen = 1'b1;
    end
    check("no_result_after_reset", 32'(seen), 0);

    // Single-shot: 16 ones, held under backpressure; start ignored in DONE; abort keeps result.
    exp_q0.push_back(exp_res(16));
    cycle(0, 1, 0, 0, 0);
    check("ss_busy_after_start", 32'(if0.busy), 1);
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 1, 1);
    check("ss_no_valid_at_15", 32'(if0.out_valid), 0);
    cycle(0, 0, 0, 1, 1);
    check("ss_valid_at_16", 32'(if0.out_valid), 1);
    check("ss_data_16", 32'(if0.out_data), 32'(exp_res(16)));
    check("ss_busy_done", 32'(if0.busy), 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 1);
    check("ss_hold_valid", 32'(if0.out_valid), 1);
    check("ss_hold_data", 32'(if0.out_data), 32'(exp_res(16)));
    cycle(0, 1, 0, 0, 0);
    check("ss_start_ignored_in_done", 32'(if0.busy), 0);
    cycle(0, 0, 1, 0, 0);
    check("ss_abort_keeps_valid", 32'(if0.out_valid), 1);
    check("ss_abort_keeps_data", 32'(if0.out_data), 32'(exp_res(16)));
    rdy[0] = 1'b1;
    cycle(0, 0, 0, 0, 0);
    check("ss_valid_drops", 32'(if0.out_valid), 0);
    check("ss_idle_after_hs", 32'(if0.busy), 0);

    // Single-shot: alternating bits with every third cycle disabled; expect 8 ones.
    exp_q0.push_back(exp_res(8));
    cycle(0, 1, 0, 0, 0);
    n_en = 0;
    k = 0;
    while (n_en < 16) begin
      if (k % 3 == 2) begin
        cycle(0, 0, 0, 1, 0);
      end else begin
        cycle(0, 0, 0, (n_en % 2 == 0), 1);
        n_en++;
        if (n_en == 15) check("gap_no_early_result", 32'(if0.out_valid), 0);
      end
      k++;
    end
    check("gap_valid", 32'(if0.out_valid), 1);
    check("gap_data", 32'(if0.out_data), 32'(exp_res(8)));
    cycle(0, 0, 0, 0, 0);
    check("gap_valid_drops", 32'(if0.out_valid), 0);
    rdy[0] = 1'b0;

    // Continuous: window A all ones, window B five ones, no consumer -> overrun.
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 1, 1);
    check("cont_a_data", 32'(if1.out_data), 32'(exp_res(16)));
    check("cont_a_overrun", 32'(if1.overrun), 0);
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, (i < 5), 1);
    check("cont_b_data", 32'(if1.out_data), 32'(exp_res(5)));
    check("cont_b_overrun", 32'(if1.overrun), 1);
    check("cont_b_busy", 32'(if1.busy), 1);
    cycle(1, 1, 0, 0, 0);
    check("cont_restart_clears_overrun", 32'(if1.overrun), 0);
    check("cont_restart_keeps_valid", 32'(if1.out_valid), 1);
    check("cont_restart_keeps_data", 32'(if1.out_data), 32'(exp_res(5)));
    exp_q1.push_back(exp_res(5));
    rdy[1] = 1'b1;
    cycle(1, 0, 0, 0, 0);
    check("cont_b_valid_drops", 32'(if1.out_valid), 0);
    rdy[1] = 1'b0;

    // Abort at sample 9, then a zero window, then a load coinciding with a handshake.
    for (int i = 0; i < 9; i++) cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 1, 1, 1);
    check("abort_idle", 32'(if1.busy), 0);
    check("abort_no_result", 32'(if1.out_valid), 0);
    exp_q1.push_back(exp_res(0));
    exp_q1.push_back(exp_res(3));
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, 1);
    check("zero_valid", 32'(if1.out_valid), 1);
    check("zero_data", 32'(if1.out_data), 32'(exp_res(0)));
    for (int i = 0; i < 15; i++) cycle(1, 0, 0, (i < 3), 1);
    rdy[1] = 1'b1;
    cycle(1, 0, 0, 0, 1);
    check("b2b_valid_held", 32'(if1.out_valid), 1);
    check("b2b_no_overrun", 32'(if1.overrun), 0);
    check("b2b_data", 32'(if1.out_data), 32'(exp_res(3)));
    cycle(1, 0, 0, 0, 0);
    check("b2b_valid_drops", 32'(if1.out_valid), 0);
    rdy[1] = 1'b0;
    cycle(1, 0, 1, 0, 0);
    check("cont_abort_idle", 32'(if1.busy), 0);

    check("single_queue_drained", 32'(exp_q0.size()), 0);
    check("cont_queue_drained", 32'(exp_q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ubit_window_acc.md
Name: ubit_window_acc

Overview:
Downstream converter for the divider stage: accumulates the unary quotient bitstream over a fixed window of 2^WIDTH qualified cycles and produces the binary estimate.
Result is presented on a valid/ready output port for capture by the host or bench.
Supports single-shot and free-running (continuous) windows; flags results lost to backpressure.

Parameters:
WIDTH, 8, window length = 2^WIDTH enabled samples; result is WIDTH+1 bits.
CONTINUOUS, 0, 0 = one window per start; 1 = windows restart back-to-back until abort.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  begin accumulation; accepted in IDLE, or in any state when CONTINUOUS=1
abort  input  1  discard partial window, return to IDLE; wins over start
in_bit  input  1  unary stream bit (quotient)
in_en  input  1  in_bit qualifier; sample counted only when 1
busy  output  1  1 while in ACC
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  WIDTH+1  ones count of last completed window
overrun  output  1  sticky: a result was overwritten before handshake

Behaviour:
- Reset (async): state IDLE, busy=0, out_valid=0, out_data=0, overrun=0, internal ones_cnt=0, sample_cnt=0.
- States: IDLE, ACC, DONE (DONE used only when CONTINUOUS=0).
- IDLE: start=1 -> ACC, ones_cnt=0, sample_cnt=0. out_valid and out_data unaffected.
- ACC: each cycle with in_en=1: ones_cnt += in_bit, sample_cnt += 1 (WIDTH bits, wraps). in_en=0 cycles are frozen; gaps do not shorten the window.
- Window end: the cycle with in_en=1 and sample_cnt=2^WIDTH-1. The final sample is included. At the next edge:
  - out_data = final count (0..2^WIDTH).
  - out_valid=1.
  - Latency: 1 cycle after the last sample.
- CONTINUOUS=0: window end -> DONE, busy=0. DONE holds out_valid/out_data until out_valid&&out_ready, then IDLE. start is ignored in DONE.
- CONTINUOUS=1: window end -> stays ACC, counters cleared, next window's first sample may arrive the very next cycle. If out_valid=1 and not handshaken in the same cycle the new result loads: out_data overwritten, overrun=1.
- Handshake: out_valid drops the cycle after out_valid&&out_ready. A new result loading in the same cycle as a handshake keeps out_valid=1 and does not set overrun.
- start while ACC (CONTINUOUS=1): restart window, clear counters, clear overrun; out_valid/out_data untouched.
- start in IDLE also clears overrun.
- abort: any state -> IDLE next edge, counters cleared. A pending out_valid/out_data is retained until handshake (handshake still honoured in IDLE). overrun is retained.
- Reset mid-window: everything returns to reset values; no partial result emitted.
- ones_cnt is WIDTH+1 bits and never overflows (max 2^WIDTH).

Optional Feature:
Macro UBIT_ACC_BIPOLAR_EN.
- Defined: out_data = ones_cnt - 2^(WIDTH-1), two's complement WIDTH+1 bits; range -2^(WIDTH-1)..+2^(WIDTH-1).
- Not defined: out_data = unsigned ones_cnt.
- Conversion is applied when the result loads; timing and handshake are identical in both builds.

Test Plan:
1. Reset: assert rst_n=0 mid-ACC -> busy=0, out_valid=0, out_data=0, overrun=0 immediately; no result after release without start.
2. WIDTH=4, CONTINUOUS=0: start, in_en=1, in_bit=1 for 16 cycles, out_ready=0 -> out_valid=1 one cycle after 16th sample, out_data=16, held 10 cycles. out_ready=1 -> out_valid=0 next cycle, state IDLE.
3. WIDTH=4: in_bit alternating 1/0, in_en low every 3rd cycle -> result only after 16 enabled samples, out_data=8.
4. WIDTH=4, CONTINUOUS=1, out_ready=0: window A all 1s, window B has 5 ones -> after B, out_data=5, overrun=1. start -> overrun=0.
5. abort at sample 9, then start with 16 zeros -> out_data=0, no stale partial count; back-to-back handshake on same cycle as new load keeps out_valid=1, overrun=0.
6. UBIT_ACC_BIPOLAR_EN, WIDTH=4: all-zero window -> out_data=5'b11000 (-8); all ones -> 5'b01000 (+8); 8 ones -> 0.
